// File: rtl/aes_host_if_if.sv
// Signal bundle between aes_host_if and its environment: request port, word-serial
// core port and response port. The master side is the host interface block itself.
interface aes_host_if_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_text;
  logic         core_ld;
  logic [31:0]  core_key;
  logic [31:0]  core_text;
  logic         core_done;
  logic [31:0]  core_text_out;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_text;
  logic [1:0]   resp_status;

  modport master (
    input  req_valid, req_key, req_text, core_done, core_text_out, resp_ready,
    output req_ready, core_ld, core_key, core_text, resp_valid, resp_text, resp_status
  );

  modport slave (
    output req_valid, req_key, req_text, core_done, core_text_out, resp_ready,
    input  req_ready, core_ld, core_key, core_text, resp_valid, resp_text, resp_status
  );
endinterface

// File: rtl/aes_host_if.sv
// Host-side initiator for the word-serial AES core: sends key/text as four 32-bit
// load words, collects the four-word result burst and returns it with a status code.
module aes_host_if #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  aes_host_if_if.master     bus,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_SHORT = 2'b10} status_t;

  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t       state;
  logic [127:0] key_sr;
  logic [127:0] text_sr;
  logic [127:0] result;
  logic [2:0]   word_cnt;
  logic [9:0]   timer;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // right-hand side sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b0;
      bus.core_ld     <= 1'b0;
      bus.core_key    <= '0;
      bus.core_text   <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_text   <= '0;
      bus.resp_status <= ST_OK;
      busy            <= 1'b0;
      key_sr          <= '0;
      text_sr         <= '0;
      result          <= '0;
      word_cnt        <= '0;
      timer           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            // Word 0 goes out straight from the request; the rest come from the shifters.
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            bus.core_ld   <= 1'b1;
            bus.core_key  <= bus.req_key[127:96];
            bus.core_text <= bus.req_text[127:96];
            key_sr        <= {bus.req_key[95:0], 32'h0};
            text_sr       <= {bus.req_text[95:0], 32'h0};
            word_cnt      <= 3'd1;
            result        <= '0;
            state         <= SEND;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        SEND: begin
          if (word_cnt == 3'd4) begin
            bus.core_ld <= 1'b0;
            timer       <= '0;
            state       <= WAIT;
          end else begin
            bus.core_key  <= key_sr[127:96];
            bus.core_text <= text_sr[127:96];
            key_sr        <= {key_sr[95:0], 32'h0};
            text_sr       <= {text_sr[95:0], 32'h0};
            word_cnt      <= word_cnt + 3'd1;
          end
        end

        WAIT: begin
          // A done word wins over the timeout when both land on the same edge.
          if (bus.core_done) begin
            result   <= {result[95:0], bus.core_text_out};
            word_cnt <= 3'd1;
            state    <= RECV;
          end else if (timer == TIMER_LAST) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_status <= ST_TIMEOUT;
            bus.resp_text   <= '0;
            state           <= RESP;
          end else begin
            timer <= timer + 10'd1;
          end
        end

        RECV: begin
          if (bus.core_done) begin
            result <= {result[95:0], bus.core_text_out};
            if (word_cnt == 3'd3) begin
              bus.resp_valid  <= 1'b1;
              bus.resp_status <= ST_OK;
              bus.resp_text   <= {result[95:0], bus.core_text_out};
              state           <= RESP;
            end else begin
              word_cnt <= word_cnt + 3'd1;
            end
          end else begin
            // Burst ended early: left-justify the words received, zero the rest.
            bus.resp_valid  <= 1'b1;
            bus.resp_status <= ST_SHORT;
            state           <= RESP;
            case (word_cnt)
              3'd1:    bus.resp_text <= {result[31:0], 96'h0};
              3'd2:    bus.resp_text <= {result[63:0], 64'h0};
              default: bus.resp_text <= {result[95:0], 32'h0};
            endcase
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_if.sv
// Scoreboard bench for aes_host_if: a core model answers each load burst, expected
// responses are queued as the core words are driven and compared on resp_valid.
module tb_aes_host_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic busy8;

  aes_host_if_if bus ();
  aes_host_if_if bus8 ();

  aes_host_if #(.TIMEOUT_CYCLES(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .busy (busy)
  );

  aes_host_if #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8.master),
    .busy (busy8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] text;
    logic [1:0]   status;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then check the four load words on the cycles after acceptance.
  task automatic send_req(input logic [127:0] key, input logic [127:0] text, input bit spur);
    int wait_cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_key   = key;
    bus.req_text  = text;
    while (bus.req_ready !== 1'b1 && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check("req_ready_seen", 128'(bus.req_ready), 128'(1));
    tick();
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_text  = '0;
    for (int i = 0; i < 4; i++) begin
      check("core_ld", 128'(bus.core_ld), 128'(1));
      check("core_key", 128'(bus.core_key), 128'(key[127-32*i -: 32]));
      check("core_text", 128'(bus.core_text), 128'(text[127-32*i -: 32]));
      check("req_ready_send", 128'(bus.req_ready), 128'(0));
      if (spur && i < 2) begin
        bus.core_done     = 1'b1;
        bus.core_text_out = 32'hDEAD_BEEF;
      end else begin
        bus.core_done     = 1'b0;
        bus.core_text_out = '0;
      end
      tick();
    end
    bus.core_done     = 1'b0;
    bus.core_text_out = '0;
    check("core_ld_end", 128'(bus.core_ld), 128'(0));
  endtask

  // Core model: after 'delay' cycles, return nwords result words (MSW first in 'words').
  task automatic core_reply(input int delay, input int nwords, input logic [191:0] words);
    resp_t        e;
    logic [127:0] acc;
    int           nrec;
    nrec = (nwords > 4) ? 4 : nwords;
    acc  = '0;
    for (int i = 0; i < nrec; i++) acc = {acc[95:0], words[191-32*i -: 32]};
    if (nrec < 4) acc = acc << (32 * (4 - nrec));
    e.text   = acc;
    e.status = (nrec == 4) ? 2'b00 : 2'b10;
    exp_q.push_back(e);
    repeat (delay) tick();
    for (int i = 0; i < nwords; i++) begin
      bus.core_done     = 1'b1;
      bus.core_text_out = words[191-32*i -: 32];
      tick();
      if (i == 3) check("resp_after_last_word", 128'(bus.resp_valid), 128'(1));
    end
    bus.core_done     = 1'b0;
    bus.core_text_out = '0;
  endtask

  // Wait for the response, compare with the scoreboard, optionally stall, then accept.
  task automatic get_resp(input int hold);
    int    cyc = 0;
    resp_t e;
    e = '0;
    while (bus.resp_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("resp_seen", 128'(bus.resp_valid), 128'(1));
    check("sb_depth", 128'(exp_q.size()), 128'(1));
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check("resp_text", bus.resp_text, e.text);
    check("resp_status", 128'(bus.resp_status), 128'(e.status));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", 128'(bus.resp_valid), 128'(1));
      check("bp_text", bus.resp_text, e.text);
      check("bp_req_ready", 128'(bus.req_ready), 128'(0));
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("resp_dropped", 128'(bus.resp_valid), 128'(0));
    check("req_ready_back", 128'(bus.req_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] nkey;
    logic [127:0] ntext;
    logic [127:0] rkey;
    logic [127:0] rtext;
    logic [191:0] rw;
    resp_t        e8;
    int           cyc;

    nkey  = 128'h000102030405060708090A0B0C0D0E0F;
    ntext = 128'h00112233445566778899AABBCCDDEEFF;
    {bus.req_valid, bus.req_key, bus.req_text, bus.core_done, bus.core_text_out, bus.resp_ready} = '0;
    {bus8.req_valid, bus8.req_key, bus8.req_text, bus8.core_done, bus8.core_text_out, bus8.resp_ready} = '0;

    // Reset values.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_core_ld", 128'(bus.core_ld), 128'(0));
    check("rst_core_key", 128'(bus.core_key), 128'(0));
    check("rst_core_text", 128'(bus.core_text), 128'(0));
    check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check("rst_resp_text", bus.resp_text, 128'(0));
    check("rst_resp_status", 128'(bus.resp_status), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    tick();
    check("first_req_ready", 128'(bus.req_ready), 128'(1));

    // Nominal transaction.
    send_req(nkey, ntext, 1'b0);
    check("busy_wait", 128'(busy), 128'(1));
    core_reply(20, 4, {128'h69C4E0D86A7B0430D8CDB78070B4C55A, 64'h0});
    get_resp(0);

    // Backpressure with a second request waiting; it must wait until K+1.
    rkey  = {$urandom, $urandom, $urandom, $urandom};
    rtext = {$urandom, $urandom, $urandom, $urandom};
    send_req(rkey, rtext, 1'b0);
    rw = {$urandom, $urandom, $urandom, $urandom, 64'h0};
    core_reply(3, 4, rw);
    bus.req_valid = 1'b1;
    bus.req_key   = ~rkey;
    bus.req_text  = ~rtext;
    get_resp(7);
    check("no_accept_at_k", 128'(bus.core_ld), 128'(0));
    send_req(~rkey, ~rtext, 1'b0);
    core_reply(0, 4, {128'h0123456789ABCDEFFEDCBA9876543210, 64'h0});
    get_resp(0);

    // Short burst: two words only.
    send_req(rkey, ntext, 1'b0);
    core_reply(5, 2, {32'hA1A1A1A1, 32'hB2B2B2B2, 128'h0});
    get_resp(0);

    // Overlong burst: words after the 4th must not disturb the held result.
    send_req(ntext, nkey, 1'b0);
    core_reply(2, 6, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                      32'h55555555, 32'h66666666});
    get_resp(2);

    // Timeout on the TIMEOUT_CYCLES=8 instance with a silent core.
    bus8.req_valid = 1'b1;
    bus8.req_key   = nkey;
    bus8.req_text  = ntext;
    cyc = 0;
    while (bus8.req_ready !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    bus8.req_valid = 1'b0;
    e8.text   = '0;
    e8.status = 2'b01;
    exp_q.push_back(e8);
    cyc = 0;
    while (bus8.resp_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("timeout_latency", 128'(cyc), 128'(12));
    e8 = exp_q.pop_front();
    check("timeout_text", bus8.resp_text, e8.text);
    check("timeout_status", 128'(bus8.resp_status), 128'(e8.status));
    for (int i = 0; i < 4; i++) begin
      bus8.core_done     = 1'b1;
      bus8.core_text_out = 32'hC0DE0000 + 32'(i);
      tick();
    end
    bus8.core_done = 1'b0;
    tick();
    check("late_done_text", bus8.resp_text, e8.text);
    check("late_done_status", 128'(bus8.resp_status), 128'(e8.status));
    check("late_done_valid", 128'(bus8.resp_valid), 128'(1));
    bus8.resp_ready = 1'b1;
    tick();
    bus8.resp_ready = 1'b0;
    check("timeout_accepted", 128'(bus8.resp_valid), 128'(0));

    // Reset during the second load word aborts the transaction.
    bus.req_valid = 1'b1;
    bus.req_key   = nkey;
    bus.req_text  = ntext;
    tick();
    bus.req_valid = 1'b0;
    check("abort_word0", 128'(bus.core_ld), 128'(1));
    tick();
    check("abort_word1", 128'(bus.core_key), 128'(nkey[95:64]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_core_ld", 128'(bus.core_ld), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_req_ready", 128'(bus.req_ready), 128'(0));
    tick();
    check("abort_req_ready_up", 128'(bus.req_ready), 128'(1));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_resp", 128'(bus.resp_valid), 128'(0));
    end
    send_req(nkey, ntext, 1'b0);
    core_reply(4, 4, {128'h69C4E0D86A7B0430D8CDB78070B4C55A, 64'h0});
    get_resp(0);

    // Spurious done pulses in IDLE and during SEND.
    for (int i = 0; i < 3; i++) begin
      bus.core_done     = 1'b1;
      bus.core_text_out = 32'hBAD0BAD0;
      tick();
      check("spur_idle_busy", 128'(busy), 128'(0));
      check("spur_idle_ready", 128'(bus.req_ready), 128'(1));
    end
    bus.core_done = 1'b0;
    tick();
    rw = {$urandom, $urandom, $urandom, $urandom, 64'h0};
    send_req(rtext, rkey, 1'b1);
    core_reply(1, 4, rw);
    get_resp(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_host_if.md
# aes_host_if

Host-side initiator for the word-serial AES core interface. Accepts one 128-bit key and one 128-bit text block through a valid/ready request port, then drives the core's load burst as four 32-bit words. It waits for the core's four-word result burst, reassembles the 128-bit result and presents it on a valid/ready response port with a status code. It is the counterpart of the core's input and output buffers: it transmits what they receive and receives what they transmit.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT cycles between the last load word and the first done word; legal range 1..1023.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_key  in  128  cipher key; sampled on accept.
- req_text  in  128  plaintext block; sampled on accept.
- core_ld  out  1  load strobe to the core; high for exactly 4 consecutive cycles per request.
- core_key  out  32  key word to the core.
- core_text  out  32  text word to the core.
- core_done  in  1  core result strobe; nominally high for 4 consecutive cycles.
- core_text_out  in  32  result word from the core, valid while core_done=1.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  response consumer ready.
- resp_text  out  128  reassembled result.
- resp_status  out  2  00 OK, 01 timeout, 10 short done burst, 11 unused.
- busy  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: req_ready=0, core_ld=0, core_key=0, core_text=0, resp_valid=0, resp_text=0, resp_status=00, busy=0. The FSM resets to IDLE, and req_ready rises at the first edge with rst low.
- IDLE: on req_valid&&req_ready, capture req_key and req_text into 128-bit shift registers, clear the word counter, and go to SEND.
- SEND: core_ld=1. core_key and core_text carry bits [127:96] first, then [95:64], [63:32], [31:0] (MSW first). After the 4th word go to WAIT and clear the timer.
- WAIT: timer increments each cycle. If core_done=1, shift core_text_out into the result register (result = {result[95:0], word}), set the received count to 1, and go to RECV. Otherwise, when the timer reaches TIMEOUT_CYCLES, go to RESP with resp_status=01 and resp_text=0. A done arriving in the same cycle as the timeout threshold wins.
- RECV: each cycle with core_done=1, shift in a word. On the 4th word go to RESP with status 00. If core_done=0 before 4 words, go to RESP with status 10; resp_text holds the partial words, left-shifted, with missing low words zero.
- RESP: resp_valid=1 and resp_text/resp_status stable until resp_valid&&resp_ready, then go to IDLE.
- core_done in IDLE, SEND or RESP is ignored and does not corrupt the held result.
- core_done longer than 4 cycles: words after the 4th are ignored.
- Reset mid-operation: abort immediately, with outputs at reset values at the next edge. Partial words are discarded and no response is issued.

## Timing
- Request accepted at edge N: req_ready=0 and core_ld=1 from N+1 through N+4 (words 0..3), core_ld=0 at N+5.
- Earliest core_done sampled is at edge N+5.
- Last (4th) done word sampled at edge M: resp_valid=1 from M+1.
- Timeout: with no done, resp_valid=1 at N+5+TIMEOUT_CYCLES, status 01.
- Response accepted at edge K: resp_valid=0 and req_ready=1 from K+1. A request is never accepted on the same edge as a response.
- Minimum request-to-request period: 4 SEND + 4 RECV + 1 RESP + 1 IDLE = 10 cycles plus core latency.
- Timer width is 10 bits and never wraps; it saturates at the threshold.

## Test plan
- Nominal: key=000102..0F, text=00112233..FF. Check core words 00010203/00112233 through 0C0D0E0F/CCDDEEFF on N+1..N+4. Core returns 69C4E0D8,6A7B0430,D8CDB780,70B4C55A after 20 cycles -> resp_text=69C4E0D86A7B0430D8CDB78070B4C55A, status 00.
- Backpressure: resp_ready held low 7 cycles -> resp_valid and resp_text stable, req_ready=0 throughout, req_valid ignored. After acceptance, a second request is accepted no earlier than K+1.
- Timeout, TIMEOUT_CYCLES=8, core silent -> resp_valid at N+13, status 01, resp_text=0. A core_done burst arriving later in RESP is ignored.
- Short burst: core_done high 2 cycles with words A1A1A1A1, B2B2B2B2 -> status 10, resp_text=A1A1A1A1B2B2B2B200000000_00000000.
- Reset mid-SEND: rst high during the 2nd ld word -> core_ld=0 next edge, no response. After release, req_ready=1 one cycle later and a fresh request completes with status 00.
- Spurious done: core_done pulses in IDLE and during SEND -> no state change, and the subsequent nominal transaction result is correct.
